// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM:
// ALU op codes, opcodes, state encoding, mux selects and the per-state
// control word.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_WB      = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEMRD   = 4'd5,
        S_MEMWR   = 4'd6,
        S_LDWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JAL     = 4'd9,
        S_JALR    = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_4     = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_MASK   = 2'd2;
    localparam logic [1:0] WB_ALUOUT    = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_PC        = 2'd2;

    // Control word registered alongside the state; only the enables that
    // depend on same-cycle inputs (mem_ready, alu_zero) are combined later.
    typedef struct packed {
        logic [3:0] alu_control;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_sel;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
    } ctrl_t;

    // DECODE successor; S_TRAP doubles as the illegal-instruction verdict.
    function automatic state_t decode_next(input logic [31:0] instr, input logic strict);
        logic       rsv_bad;
        logic [2:0] f3;
        state_t     nxt;
        f3      = instr[14:12];
        rsv_bad = strict && (instr[31] || (|instr[29:25]));
        nxt     = S_TRAP;
        case (instr[6:0])
            OP_R:              if (!rsv_bad) nxt = S_EXEC;
            // funct3 x01 are the shift-immediates, the only I-types with a funct7
            OP_IMM:            if (!(rsv_bad && f3[1:0] == 2'b01)) nxt = S_EXEC;
            OP_LUI, OP_AUIPC:  nxt = S_EXEC;
            OP_LOAD, OP_STORE: if (f3 == 3'b010) nxt = S_MEMADDR;
            OP_BRANCH:         if (f3[2:1] != 2'b01) nxt = S_BRANCH;
            OP_JAL:            nxt = S_JAL;
            OP_JALR:           if (f3 == 3'b000) nxt = S_JALR;
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // Moore part of the outputs for the state being entered.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [31:0] instr,
                                       input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.src_a   = SRCA_PC;
                c.src_b   = SRCB_4;
                c.pc_src  = PCSRC_ALU;
            end
            S_DECODE: begin
                c.src_a   = SRCA_OLDPC;
                c.src_b   = SRCB_IMM;
                c.imm_sel = IMM_B;
            end
            S_EXEC: begin
                case (instr[6:0])
                    OP_R:     begin c.src_a = SRCA_RS1;   c.src_b = SRCB_RS2; c.alu_control = op; end
                    OP_IMM:   begin c.src_a = SRCA_RS1;   c.src_b = SRCB_IMM; c.alu_control = op; end
                    OP_LUI:   begin c.src_a = SRCA_ZERO;  c.src_b = SRCB_IMM; c.imm_sel = IMM_U; end
                    OP_AUIPC: begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; c.imm_sel = IMM_U; end
                    default:  c = '0;
                endcase
            end
            S_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = WB_ALUOUT;
            end
            S_MEMADDR: begin
                c.src_a   = SRCA_RS1;
                c.src_b   = SRCB_IMM;
                c.imm_sel = instr[5] ? IMM_S : IMM_I;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_LDWB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = WB_MDR;
            end
            S_BRANCH: begin
                c.src_a       = SRCA_RS1;
                c.src_b       = SRCB_RS2;
                c.alu_control = op;
                c.pc_src      = PCSRC_ALUOUT;
            end
            S_JAL: begin
                c.src_a     = SRCA_OLDPC;
                c.src_b     = SRCB_IMM;
                c.imm_sel   = IMM_J;
                c.pc_write  = 1'b1;
                c.reg_write = 1'b1;
                c.wb_sel    = WB_PC;
            end
            S_JALR: begin
                c.src_a     = SRCA_RS1;
                c.src_b     = SRCB_IMM;
                c.imm_sel   = IMM_I;
                c.pc_write  = 1'b1;
                c.pc_src    = PCSRC_MASK;
                c.reg_write = 1'b1;
                c.wb_sel    = WB_PC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. master = control FSM.
interface multicycle_control_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic [3:0]  alu_control;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_sel;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        old_pc_write;
    logic        ir_write;
    logic        mdr_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        illegal;
    logic        bus_err;
    logic [3:0]  state_o;

    modport master (
        input  instr, alu_zero, mem_ready,
        output alu_control, alu_src_a, alu_src_b, imm_sel, pc_write, pc_src,
               old_pc_write, ir_write, mdr_write, reg_write, wb_sel,
               mem_req, mem_we, iord, illegal, bus_err, state_o
    );

    modport slave (
        output instr, alu_zero, mem_ready,
        input  alu_control, alu_src_a, alu_src_b, imm_sel, pc_write, pc_src,
               old_pc_write, ir_write, mdr_write, reg_write, wb_sel,
               mem_req, mem_we, iord, illegal, bus_err, state_o
    );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational ALU op decode from opcode, funct3 and funct7[5].
module multicycle_control_alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_control
);

    // R/I arithmetic by funct3; branches compare with SUB/SLT/SLTU
    always_comb begin
        alu_control = ALU_ADD;
        case (opcode)
            OP_R, OP_IMM: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: one instruction in flight, registered
// control word, sticky illegal/bus_err traps.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STRICT_DECODE = 1,
    parameter int BUS_TIMEOUT   = 0
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    localparam logic [15:0] WAIT_LAST = 16'(BUS_TIMEOUT - 1);

    state_t      state, state_nxt;
    ctrl_t       ctrl_q;
    logic [15:0] wait_cnt;
    logic [3:0]  alu_op;
    logic        req_done, timeout, fetch_done, taken;
    logic        illegal_q, bus_err_q;

    multicycle_control_alu_op_decode u_alu_op_decode (
        .opcode      (bus.instr[6:0]),
        .funct3      (bus.instr[14:12]),
        .funct7_b5   (bus.instr[30]),
        .alu_control (alu_op)
    );

    // mem_ready only counts while our own request is up
    assign req_done   = ctrl_q.mem_req && bus.mem_ready;
    assign timeout    = (BUS_TIMEOUT != 0) && ctrl_q.mem_req && !bus.mem_ready
                        && (wait_cnt == WAIT_LAST);
    assign fetch_done = (state == S_FETCH) && req_done;
    // BEQ/BGE(U) take on zero, BNE/BLT(U) on !zero
    assign taken      = bus.alu_zero ^ bus.instr[12] ^ bus.instr[14];

    // Next-state selection; a bus timeout overrides any memory state
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (req_done) state_nxt = S_DECODE;
            S_DECODE:  state_nxt = decode_next(bus.instr, STRICT_DECODE != 0);
            S_EXEC:    state_nxt = S_WB;
            S_WB:      state_nxt = S_FETCH;
            S_MEMADDR: state_nxt = bus.instr[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (req_done) state_nxt = S_LDWB;
            S_MEMWR:   if (req_done) state_nxt = S_FETCH;
            S_LDWB, S_BRANCH, S_JAL, S_JALR: state_nxt = S_FETCH;
            default:   state_nxt = S_TRAP;
        endcase
        if (timeout) state_nxt = S_TRAP;
    end

    // State, registered control word, per-request wait counter, sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            ctrl_q    <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl_q   <= ctrl_for(state_nxt, bus.instr, alu_op);
            wait_cnt <= (ctrl_q.mem_req && !bus.mem_ready) ? wait_cnt + 16'd1 : '0;
            if (state == S_DECODE && state_nxt == S_TRAP) illegal_q <= 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

    assign bus.alu_control  = ctrl_q.alu_control;
    assign bus.alu_src_a    = ctrl_q.src_a;
    assign bus.alu_src_b    = ctrl_q.src_b;
    assign bus.imm_sel      = ctrl_q.imm_sel;
    assign bus.pc_src       = ctrl_q.pc_src;
    assign bus.reg_write    = ctrl_q.reg_write;
    assign bus.wb_sel       = ctrl_q.wb_sel;
    assign bus.mem_req      = ctrl_q.mem_req;
    assign bus.mem_we       = ctrl_q.mem_we;
    assign bus.iord         = ctrl_q.iord;
    assign bus.pc_write     = ctrl_q.pc_write || fetch_done || (state == S_BRANCH && taken);
    assign bus.ir_write     = fetch_done;
    assign bus.old_pc_write = fetch_done;
    assign bus.mdr_write    = (state == S_MEMRD) && req_done;
    assign bus.illegal      = illegal_q;
    assign bus.bus_err      = bus_err_q;
    assign bus.state_o      = state;

endmodule
